// File: rtl/muldiv_pkg.sv
// ----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the multi-cycle multiply/divide unit:
//   - op_i encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU)
//   - FSM state enumeration
//   - counter width helper, $clog2(width)+1
// ----------------------------------------------------------------------------
package muldiv_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MUL  = 2'b01,
      ST_DIV  = 2'b10,
      ST_SIGN = 2'b11
   } stateT;

   // Iteration counter width for a given operand width.
   function automatic int cntWidth(input int w);
      return $clog2(w) + 1;
   endfunction

   localparam int CNT_W = cntWidth(32);

endpackage

// File: rtl/muldiv_unit_div_core.sv
// ----------------------------------------------------------------------------
// div_core
// Restoring radix-2 divider datapath on unsigned magnitudes. One quotient bit
// per step, MSB first. The dividend is shifted out of the quotient register
// while quotient bits are shifted in from the right.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   load          capture dividend/divisor, clear remainder, counter=WIDTH-1
//   step          perform one iteration
//   dividend      unsigned dividend magnitude
//   divisor       unsigned divisor magnitude
//   quotient      quotient (valid after WIDTH steps)
//   remainder     remainder (valid after WIDTH steps)
//   last          iteration counter is zero (current step is the final one)
// ----------------------------------------------------------------------------
module div_core
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CW    = cntWidth(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             last
);

   localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

   logic [WIDTH-1:0] quoR;
   logic [WIDTH-1:0] remR;
   logic [WIDTH-1:0] divR;
   logic [CW-1:0]    cntR;

   logic [WIDTH:0]   remShiftS;
   logic [WIDTH:0]   diffS;
   logic [WIDTH-1:0] remNextS;
   logic             qBitS;

   // Trial subtraction: bit WIDTH of the difference acts as the borrow.
   always_comb begin
      remShiftS = {remR, quoR[WIDTH-1]};
      diffS     = remShiftS - {1'b0, divR};
      if (diffS[WIDTH]) begin
         remNextS = remShiftS[WIDTH-1:0];
         qBitS    = 1'b0;
      end else begin
         remNextS = diffS[WIDTH-1:0];
         qBitS    = 1'b1;
      end
   end

   // Iteration registers and counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         quoR <= {WIDTH{1'b0}};
         remR <= {WIDTH{1'b0}};
         divR <= {WIDTH{1'b0}};
         cntR <= {CW{1'b0}};
      end else if (load) begin
         quoR <= dividend;
         remR <= {WIDTH{1'b0}};
         divR <= divisor;
         cntR <= CNT_LOAD;
      end else if (step) begin
         quoR <= {quoR[WIDTH-2:0], qBitS};
         remR <= remNextS;
         if (cntR != {CW{1'b0}}) begin
            cntR <= cntR - CW'(1);
         end else begin
            cntR <= cntR;
         end
      end else begin
         quoR <= quoR;
         remR <= remR;
         divR <= divR;
         cntR <= cntR;
      end
   end

   assign quotient  = quoR;
   assign remainder = remR;
   assign last      = (cntR == {CW{1'b0}});

endmodule

// File: rtl/muldiv_unit.sv
// ----------------------------------------------------------------------------
// muldiv_unit
// Multi-cycle signed/unsigned multiply/divide unit feeding HI/LO.
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   start_i   request, sampled only in IDLE
//   op_i      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a_i, b_i  multiplicand/dividend, multiplier/divisor
//   annul_i   synchronous abort; next edge returns to IDLE, results untouched
//   busy_o    stall request (registered)
//   done_o    one-cycle result-valid pulse (registered)
//   hi_o      product high half / remainder
//   lo_o      product low half / quotient
//   dbz_o     divide-by-zero flag, held with the result
// Configuration macro: DIV_EARLY_OUT_EN -- divides with |a| < |b|, b != 0,
//   skip the iterations and complete after edge 2.
// ----------------------------------------------------------------------------
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int MUL_LATENCY = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             annul_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic             dbz_o
);

   localparam int CW = cntWidth(WIDTH);
   localparam int MW = 2 * WIDTH;
   localparam int LW = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
   localparam logic [LW-1:0] LAT_LOAD = LW'(MUL_LATENCY - 1);

   stateT            stateR;
   logic             busyR, doneR, dbzR;
   logic [WIDTH-1:0] hiR, loR;
   logic [WIDTH-1:0] aR, bR;
   logic             mulSignedR, negQR, negRR, bZeroR, earlyR, waitR;
   logic [LW-1:0]    latCntR;

   logic             isDivS, signedS, negAS, negBS, bZeroS, earlyS;
   logic [WIDTH-1:0] magAS, magBS;
   logic             divLoadS, divStepS, divLastS;
   logic [WIDTH-1:0] divQuoS, divRemS, quoFixS, remFixS;
   logic [MW-1:0]    extAS, extBS, prodS, mulResS;

   // Request decode and operand magnitudes for the divider.
   always_comb begin
      isDivS  = (op_i == OP_DIV) | (op_i == OP_DIVU);
      signedS = (op_i == OP_MULT) | (op_i == OP_DIV);
      negAS   = signedS & a_i[WIDTH-1];
      negBS   = signedS & b_i[WIDTH-1];
      if (negAS) begin
         magAS = {WIDTH{1'b0}} - a_i;
      end else begin
         magAS = a_i;
      end
      if (negBS) begin
         magBS = {WIDTH{1'b0}} - b_i;
      end else begin
         magBS = b_i;
      end
      bZeroS = (b_i == {WIDTH{1'b0}});
`ifdef DIV_EARLY_OUT_EN
      earlyS = ~bZeroS & (magAS < magBS);
`else
      earlyS = 1'b0;
`endif
   end

   assign divLoadS = (stateR == ST_IDLE) & start_i & ~annul_i & isDivS;
   assign divStepS = (stateR == ST_DIV) & ~annul_i;

   div_core #(
      .WIDTH (WIDTH),
      .CW    (CW)
   ) uDivCore (
      .clk       (clk),
      .rst       (rst),
      .load      (divLoadS),
      .step      (divStepS),
      .dividend  (magAS),
      .divisor   (magBS),
      .quotient  (divQuoS),
      .remainder (divRemS),
      .last      (divLastS)
   );

   // Sign correction: quotient negated on differing signs, remainder follows dividend.
   always_comb begin
      if (negQR) begin
         quoFixS = {WIDTH{1'b0}} - divQuoS;
      end else begin
         quoFixS = divQuoS;
      end
      if (negRR) begin
         remFixS = {WIDTH{1'b0}} - divRemS;
      end else begin
         remFixS = divRemS;
      end
   end

   // Full-width product; sign extension to 2*WIDTH gives the signed result in the low bits.
   always_comb begin
      if (mulSignedR) begin
         extAS = {{WIDTH{aR[WIDTH-1]}}, aR};
         extBS = {{WIDTH{bR[WIDTH-1]}}, bR};
      end else begin
         extAS = {{WIDTH{1'b0}}, aR};
         extBS = {{WIDTH{1'b0}}, bR};
      end
      prodS = extAS * extBS;
   end

   // The operand latch is the first stage; MUL_LATENCY-1 product registers follow.
   generate
      if (MUL_LATENCY == 1) begin : gMulComb
         assign mulResS = prodS;
      end else begin : gMulPipe
         logic [MW-1:0] pipeR [MUL_LATENCY-1];
         // Free-running product pipeline.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               for (int i = 0; i < MUL_LATENCY - 1; i++) begin
                  pipeR[i] <= {MW{1'b0}};
               end
            end else begin
               pipeR[0] <= prodS;
               for (int i = 1; i < MUL_LATENCY - 1; i++) begin
                  pipeR[i] <= pipeR[i-1];
               end
            end
         end
         assign mulResS = pipeR[MUL_LATENCY-2];
      end
   endgenerate

   // Control FSM with registered handshake and result outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stateR     <= ST_IDLE;
         busyR      <= 1'b0;
         doneR      <= 1'b0;
         dbzR       <= 1'b0;
         hiR        <= {WIDTH{1'b0}};
         loR        <= {WIDTH{1'b0}};
         aR         <= {WIDTH{1'b0}};
         bR         <= {WIDTH{1'b0}};
         mulSignedR <= 1'b0;
         negQR      <= 1'b0;
         negRR      <= 1'b0;
         bZeroR     <= 1'b0;
         earlyR     <= 1'b0;
         waitR      <= 1'b0;
         latCntR    <= {LW{1'b0}};
      end else if (annul_i) begin
         // Abort wins over everything, including a start in IDLE.
         stateR  <= ST_IDLE;
         busyR   <= 1'b0;
         doneR   <= 1'b0;
         waitR   <= 1'b0;
         latCntR <= {LW{1'b0}};
      end else begin
         case (stateR)
            ST_IDLE: begin
               doneR <= 1'b0;
               if (start_i) begin
                  aR         <= a_i;
                  bR         <= b_i;
                  mulSignedR <= signedS;
                  negQR      <= negAS ^ negBS;
                  negRR      <= negAS;
                  bZeroR     <= bZeroS;
                  busyR      <= 1'b1;
                  if (isDivS) begin
                     earlyR <= earlyS;
                     // Early-out spends one extra SIGN cycle so done lands after edge 2.
                     waitR  <= earlyS;
                     if (earlyS) begin
                        stateR <= ST_SIGN;
                     end else begin
                        stateR <= ST_DIV;
                     end
                  end else begin
                     earlyR  <= 1'b0;
                     waitR   <= 1'b0;
                     latCntR <= LAT_LOAD;
                     stateR  <= ST_MUL;
                  end
               end else begin
                  busyR <= 1'b0;
               end
            end
            ST_MUL: begin
               if (latCntR == {LW{1'b0}}) begin
                  hiR    <= mulResS[MW-1:WIDTH];
                  loR    <= mulResS[WIDTH-1:0];
                  dbzR   <= 1'b0;
                  doneR  <= 1'b1;
                  busyR  <= 1'b0;
                  stateR <= ST_IDLE;
               end else begin
                  latCntR <= latCntR - LW'(1);
               end
            end
            ST_DIV: begin
               // div_core performs the final iteration on the same edge.
               if (divLastS) begin
                  stateR <= ST_SIGN;
               end else begin
                  stateR <= ST_DIV;
               end
            end
            ST_SIGN: begin
               if (waitR) begin
                  waitR <= 1'b0;
               end else begin
                  if (bZeroR) begin
                     loR  <= {WIDTH{1'b1}};
                     hiR  <= aR;
                     dbzR <= 1'b1;
                  end else if (earlyR) begin
                     loR  <= {WIDTH{1'b0}};
                     hiR  <= aR;
                     dbzR <= 1'b0;
                  end else begin
                     loR  <= quoFixS;
                     hiR  <= remFixS;
                     dbzR <= 1'b0;
                  end
                  doneR  <= 1'b1;
                  busyR  <= 1'b0;
                  stateR <= ST_IDLE;
               end
            end
            default: begin
               stateR <= ST_IDLE;
               busyR  <= 1'b0;
               doneR  <= 1'b0;
            end
         endcase
      end
   end

   assign busy_o = busyR;
   assign done_o = doneR;
   assign hi_o   = hiR;
   assign lo_o   = loR;
   assign dbz_o  = dbzR;

endmodule

// File: tb/tb_muldiv_unit.sv
// ----------------------------------------------------------------------------
// tb_muldiv_unit
// Table-driven directed vectors, hand-written sequences for annul / ignored
// start / async reset, and randomized operations checked against an
// arithmetic reference model. WIDTH=32, MUL_LATENCY=2.
// ----------------------------------------------------------------------------
module tb_muldiv_unit;

   localparam int W = 32;
   localparam int L = 2;
   localparam int DIV_LAT = W + 1;
`ifdef DIV_EARLY_OUT_EN
   localparam int EL = 2;
`else
   localparam int EL = DIV_LAT;
`endif

   logic          clk, rst, start_i, annul_i;
   logic [1:0]    op_i;
   logic [W-1:0]  a_i, b_i;
   logic          busy_o, done_o, dbz_o;
   logic [W-1:0]  hi_o, lo_o;

   int nVec = 0;
   int nMiss = 0;

   muldiv_unit #(.WIDTH(W), .MUL_LATENCY(L)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
      .a_i(a_i), .b_i(b_i), .annul_i(annul_i),
      .busy_o(busy_o), .done_o(done_o),
      .hi_o(hi_o), .lo_o(lo_o), .dbz_o(dbz_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dbz;
      int           lat;
   } vecT;

   vecT tbl [13];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nVec++;
      if (act !== exp) begin
         nMiss++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Arithmetic reference: 64-bit products and truncating division.
   function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] hi, output logic [W-1:0] lo,
                                 output logic dbz, output int lat);
      longint sa, sb, q, r, ma, mb;
      logic [63:0] p;
      if (op[0]) begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end else begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end
      dbz = 1'b0;
      if (!op[1]) begin
         p   = 64'(sa * sb);
         hi  = p[63:32];
         lo  = p[31:0];
         lat = L;
      end else if (b == 32'd0) begin
         hi  = a;
         lo  = 32'hFFFF_FFFF;
         dbz = 1'b1;
         lat = DIV_LAT;
      end else begin
         q   = sa / sb;
         r   = sa % sb;
         p   = 64'(q);
         lo  = p[31:0];
         p   = 64'(r);
         hi  = p[31:0];
         ma  = (sa < 0) ? -sa : sa;
         mb  = (sb < 0) ? -sb : sb;
         lat = (ma < mb) ? EL : DIV_LAT;
      end
   endfunction

   task automatic startOp(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      start_i = 1'b1;
      op_i    = op;
      a_i     = a;
      b_i     = b;
      @(posedge clk);
      #1;
      start_i = 1'b0;
   endtask

   // Counts edges after edge 0 until done_o; lat=-1 when the budget expires.
   task automatic waitDone(output int lat, output int busyCyc, output logic busyAtDone);
      lat = -1;
      busyCyc = 0;
      busyAtDone = 1'bx;
      for (int k = 1; k <= 100; k++) begin
         if (busy_o) busyCyc++;
         @(posedge clk);
         #1;
         if (done_o) begin
            lat = k;
            busyAtDone = busy_o;
            break;
         end
      end
   endtask

   task automatic runCheck(input string name, input logic [1:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] eHi, input logic [W-1:0] eLo,
                           input logic eDbz, input int eLat);
      int lat, busyCyc;
      logic busyAtDone;
      startOp(op, a, b);
      waitDone(lat, busyCyc, busyAtDone);
      chk({name, ".lat"}, 64'(lat), 64'(eLat));
      chk({name, ".busyCyc"}, 64'(busyCyc), 64'(eLat));
      chk({name, ".busyAtDone"}, {63'd0, busyAtDone}, 64'd0);
      chk({name, ".hi"}, {32'd0, hi_o}, {32'd0, eHi});
      chk({name, ".lo"}, {32'd0, lo_o}, {32'd0, eLo});
      chk({name, ".dbz"}, {63'd0, dbz_o}, {63'd0, eDbz});
   endtask

   initial begin
      logic [W-1:0] eHi, eLo, ra, rb;
      logic [1:0]   rop;
      logic         eDbz, sawDone;
      int           eLat, lat, busyCyc, mode;
      logic         busyAtDone;

      tbl[0]  = '{2'b00, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, L};
      tbl[1]  = '{2'b01, 32'hFFFF_FFFE, 32'd3,         32'h0000_0002, 32'hFFFF_FFFA, 1'b0, L};
      tbl[2]  = '{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, DIV_LAT};
      tbl[3]  = '{2'b11, 32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF, 1'b1, DIV_LAT};
      tbl[4]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0, DIV_LAT};
      tbl[5]  = '{2'b11, 32'd5,         32'd9,         32'd5,         32'd0,         1'b0, EL};
      tbl[6]  = '{2'b10, 32'hFFFF_FFFB, 32'd9,         32'hFFFF_FFFB, 32'd0,         1'b0, EL};
      tbl[7]  = '{2'b10, 32'd100,       32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFF2, 1'b0, DIV_LAT};
      tbl[8]  = '{2'b10, 32'd0,         32'd5,         32'd0,         32'd0,         1'b0, EL};
      tbl[9]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         1'b0, L};
      tbl[10] = '{2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, DIV_LAT};
      tbl[11] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1,         1'b0, L};
      tbl[12] = '{2'b11, 32'hFFFF_FFFF, 32'd2,         32'd1,         32'h7FFF_FFFF, 1'b0, DIV_LAT};

      rst = 1'b0; start_i = 1'b0; annul_i = 1'b0; op_i = 2'b00; a_i = '0; b_i = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("reset.busy", {63'd0, busy_o}, 64'd0);
      chk("reset.done", {63'd0, done_o}, 64'd0);
      chk("reset.hi", {32'd0, hi_o}, 64'd0);
      chk("reset.lo", {32'd0, lo_o}, 64'd0);
      chk("reset.dbz", {63'd0, dbz_o}, 64'd0);

      // Directed table; consecutive entries also exercise start in the done cycle.
      for (int i = 0; i < 13; i++) begin
         runCheck($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
                  tbl[i].hi, tbl[i].lo, tbl[i].dbz, tbl[i].lat);
      end

      // Annul mid-divide: no done, previous result (MULTU) kept, then a MULT completes.
      runCheck("preAnnul", 2'b01, 32'hFFFF_FFFE, 32'd3, 32'h2, 32'hFFFF_FFFA, 1'b0, L);
      startOp(2'b10, 32'hFFFF_FFF9, 32'd2);
      repeat (10) begin
         @(posedge clk);
         #1;
      end
      annul_i = 1'b1;
      @(posedge clk);
      #1;
      annul_i = 1'b0;
      chk("annul.busy", {63'd0, busy_o}, 64'd0);
      sawDone = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (done_o) sawDone = 1'b1;
         @(posedge clk);
         #1;
      end
      chk("annul.noDone", {63'd0, sawDone}, 64'd0);
      chk("annul.hiKept", {32'd0, hi_o}, 64'h2);
      chk("annul.loKept", {32'd0, lo_o}, 64'hFFFF_FFFA);
      runCheck("postAnnul", 2'b00, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, L);

      // Start while busy is ignored.
      startOp(2'b11, 32'd100, 32'd7);
      repeat (3) @(posedge clk);
      @(negedge clk);
      start_i = 1'b1; op_i = 2'b00; a_i = 32'd5; b_i = 32'd5;
      @(negedge clk);
      start_i = 1'b0;
      waitDone(lat, busyCyc, busyAtDone);
      chk("ignore.lat", 64'(lat + 4), 64'(DIV_LAT));
      chk("ignore.hi", {32'd0, hi_o}, 64'd2);
      chk("ignore.lo", {32'd0, lo_o}, 64'd14);
      @(posedge clk);
      #1;
      chk("ignore.donePulse", {63'd0, done_o}, 64'd0);
      chk("ignore.noRestart", {63'd0, busy_o}, 64'd0);

      // Annul and start in the same IDLE cycle: request dropped.
      @(negedge clk);
      start_i = 1'b1; annul_i = 1'b1; op_i = 2'b00; a_i = 32'd9; b_i = 32'd9;
      @(posedge clk);
      #1;
      start_i = 1'b0; annul_i = 1'b0;
      chk("annulStart.busy", {63'd0, busy_o}, 64'd0);
      sawDone = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (done_o) sawDone = 1'b1;
         @(posedge clk);
         #1;
      end
      chk("annulStart.noDone", {63'd0, sawDone}, 64'd0);
      chk("annulStart.lo", {32'd0, lo_o}, 64'd14);

      // Randomized operations against the reference model.
      for (int n = 0; n < 40; n++) begin
         rop  = 2'($urandom_range(0, 3));
         mode = int'($urandom_range(0, 3));
         ra = $urandom;
         rb = $urandom;
         case (mode)
            1: begin
               ra = 32'($urandom_range(0, 40)) - 32'd20;
               rb = 32'($urandom_range(0, 40)) - 32'd20;
            end
            2: rb = 32'd0;
            3: ra = 32'($urandom_range(0, 100));
            default: ;
         endcase
         model(rop, ra, rb, eHi, eLo, eDbz, eLat);
         runCheck($sformatf("rnd%0d", n), rop, ra, rb, eHi, eLo, eDbz, eLat);
      end

      // Asynchronous reset in the middle of a divide.
      runCheck("preReset", 2'b00, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, L);
      startOp(2'b10, 32'd1000, 32'd3);
      repeat (5) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("asyncRst.busy", {63'd0, busy_o}, 64'd0);
      chk("asyncRst.done", {63'd0, done_o}, 64'd0);
      chk("asyncRst.hi", {32'd0, hi_o}, 64'd0);
      chk("asyncRst.lo", {32'd0, lo_o}, 64'd0);
      chk("asyncRst.dbz", {63'd0, dbz_o}, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      runCheck("postReset", 2'b11, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0, DIV_LAT);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised multi-cycle multiply/divide unit for the execute stage. It replaces the fixed 32-bit mult/div path feeding the HI/LO register. It accepts signed or unsigned MULT/DIV operations through a start/busy/done handshake and raises a stall request while it is computing. An in-flight operation can be annulled by an exception flush without side effects on the HI/LO results.

## Interface
Parameters:
- WIDTH, 32, operand width; hi_o/lo_o are each WIDTH bits.
- MUL_LATENCY, 2, edges from start to result for multiplies (≥1).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-low.
- start_i  in  1  request; sampled only in IDLE.
- op_i  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- a_i  in  WIDTH  multiplicand / dividend.
- b_i  in  WIDTH  multiplier / divisor.
- annul_i  in  1  synchronous abort (exception flush).
- busy_o  out  1  stall request to hazard logic.
- done_o  out  1  one-cycle pulse, result valid.
- hi_o  out  WIDTH  product high half / remainder.
- lo_o  out  WIDTH  product low half / quotient.
- dbz_o  out  1  divide-by-zero flag; valid with done_o and held with the result.

## Operation
- FSM states: IDLE, MUL, DIV, SIGN.
- IDLE + start_i & ~annul_i:
  - Latch the operands and op.
  - MULT/MULTU goes to MUL and loads the latency counter with MUL_LATENCY-1.
  - DIV/DIVU converts the operands to magnitudes, then goes to DIV with the iteration counter at WIDTH-1.
- MUL:
  - Compute a 2·WIDTH product (signed for MULT, zero-extended for MULTU).
  - Pass it through MUL_LATENCY register stages.
  - When the counter reaches 0, write hi/lo, pulse done_o and return to IDLE.
- DIV:
  - Restoring radix-2, one quotient bit per edge, MSB first.
  - After WIDTH iterations go to SIGN.
- SIGN:
  - Quotient is negated if the operand signs differ (signed only).
  - Remainder takes the sign of the dividend.
  - Write hi = remainder and lo = quotient, pulse done_o, return to IDLE.
- Divide by zero: lo = all ones, hi = a_i, dbz_o = 1. Full iteration count still applies.
- Signed MIN / -1: lo = MIN, hi = 0, dbz_o = 0.
- start_i while not IDLE is ignored (not queued).
- annul_i in any state: the next edge returns to IDLE. No done_o pulse; hi_o/lo_o/dbz_o unchanged.
- annul_i and start_i in the same IDLE cycle: annul wins and the request is dropped.
- hi_o/lo_o/dbz_o hold the last result until the next done_o.

## Timing
- Reset values: FSM IDLE, busy_o 0, done_o 0, hi_o 0, lo_o 0, dbz_o 0, all counters 0.
- Reset asserted mid-operation aborts the operation immediately (asynchronous), with the reset values above.
- Start edge = edge 0.
- Multiply: done_o is high during the cycle following edge MUL_LATENCY.
- Divide: done_o is high after edge WIDTH+1 (WIDTH iterations plus SIGN).
- busy_o:
  - High from edge 0 until the edge that asserts done_o.
  - Low in the done_o cycle, so the pipeline advances while the result is visible.
  - Never high in IDLE.
- done_o and busy_o are registered outputs; there is no combinational path from inputs.
- Back-to-back: a start in the done_o cycle is accepted, because the FSM is already in IDLE.

## Configuration
- Macro: DIV_EARLY_OUT_EN.
- When defined:
  - A DIV/DIVU with |a| < |b| and b ≠ 0 (including a = 0) skips the iterations: the start goes straight to SIGN.
  - Result is lo = 0, hi = a_i (sign kept), with done_o after edge 2.
  - busy_o is high for exactly edges 0..1.
- When undefined: every divide takes WIDTH+1 edges. The comparator is not built.

## Structure
- Package muldiv_pkg holds:
  - the op_i encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU);
  - the FSM state enum;
  - a localparam for the counter width, $clog2(WIDTH)+1.
- One sub-module, div_core, holds the restoring iteration datapath: remainder/quotient shift registers, subtractor and iteration counter, with load/step/done signals. The FSM and the multiply pipeline stay in muldiv_unit.

## Test plan
WIDTH=32, MUL_LATENCY=2.
- MULT a=0xFFFFFFFE, b=3 → done after edge 2; hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy_o high for 2 cycles.
- MULTU a=0xFFFFFFFE, b=3 → hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=-7, b=2 → done after edge 33; lo=0xFFFFFFFD, hi=0xFFFFFFFF, dbz_o=0.
- DIVU a=7, b=0 → done after edge 33; dbz_o=1, lo=0xFFFFFFFF, hi=7.
- DIV in flight, annul_i at edge 10 → IDLE at edge 11, no done_o, prior hi/lo kept. A new MULT on the next cycle completes normally.
- DIVU a=5, b=9 → with DIV_EARLY_OUT_EN: done after edge 2, lo=0, hi=5. Without the macro: done after edge 33, same values.
